fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have the parameter NUM_REQ, default 4, giving the number of requesters sharing one FIFO write port.
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 128, giving the write data width.
REQ-003 The block SHALL have the parameter MAX_BURST, default 4, giving the maximum number of consecutive grants to one requester.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have the port arst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have the port req, input, NUM_REQ bits: per-requester write request, level-held until granted.
REQ-007 The block SHALL have the port data, input, NUM_REQ x DATA_WIDTH: per-requester write word, valid while req is high.
REQ-008 The block SHALL have the port gnt, output, NUM_REQ bits: combinational one-hot accept; the word is consumed in any cycle where req[i] & gnt[i].
REQ-009 The block SHALL have the port fifo_wr, output, 1 bit: registered FIFO write strobe.
REQ-010 The block SHALL have the port fifo_data, output, DATA_WIDTH: registered FIFO write word.
REQ-011 The block SHALL have the port fifo_full, input, 1 bit: FIFO full flag.
REQ-012 The block SHALL have the port fifo_almost_full, input, 1 bit: FIFO flag meaning exactly one free slot remains.
REQ-013 The block SHALL have the port owner, output, $clog2(NUM_REQ) bits: the current burst owner; it is valid only while busy is high.
REQ-014 The block SHALL have the port busy, output, 1 bit: high while the state is BURST.

Function
REQ-015 The block SHALL compute space = !fifo_full & !(fifo_almost_full & fifo_wr), so that the one write in flight is accounted for.
REQ-016 The block SHALL assert at most one gnt bit per cycle, and SHALL assert gnt[i] only when req[i] and space are both high.
REQ-017 The block SHALL have two states, IDLE and BURST, held in state register st.
REQ-018 In IDLE with any req and space, the block SHALL grant the first requesting index at or after rr_ptr (cyclic search), set owner to that index, set burst_cnt to 1, and go to BURST.
REQ-019 In BURST, when req[owner], space and burst_cnt < MAX_BURST all hold, the block SHALL grant owner and increment burst_cnt.
REQ-020 In BURST, when req[owner] is low or burst_cnt == MAX_BURST, the block SHALL set rr_ptr to owner+1 (mod NUM_REQ) and arbitrate per REQ-018 in the same cycle from that pointer, with no idle gap.
REQ-021 If the arbitration in REQ-020 finds no requester or no space, the block SHALL go to IDLE.
REQ-022 The previous owner SHALL win re-arbitration only if no other requester is active.
REQ-023 When space is low, the block SHALL assert no gnt and SHALL hold st, owner, burst_cnt and rr_ptr; stall cycles SHALL NOT consume burst budget.
REQ-024 If req[owner] drops during a stall, the block SHALL apply REQ-020 once space returns.
REQ-025 The block SHALL set fifo_wr one cycle after a grant cycle, equal to |gnt of that cycle, with fifo_data equal to the granted word; latency from grant to FIFO write is exactly 1 cycle.
REQ-026 When there is no grant, the block SHALL drive fifo_wr to 0 and SHALL hold fifo_data.
REQ-027 rr_ptr and owner arithmetic SHALL wrap modulo NUM_REQ, and NUM_REQ SHALL be allowed to be a non-power of 2.
REQ-028 burst_cnt SHALL be $clog2(MAX_BURST+1) bits wide.
REQ-029 With MAX_BURST=1, the block SHALL alternate strictly round-robin.

Reset
REQ-030 While arst is high, the block SHALL force st=IDLE, rr_ptr=0, owner=0, burst_cnt=0, fifo_wr=0, fifo_data=0, gnt=0 and busy=0.
REQ-031 When arst is asserted mid-burst, a word granted in the same cycle SHALL be lost and SHALL NOT be written.
REQ-032 The first grant after reset release SHALL favour requester 0.

Structure
REQ-033 The shared package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default values of NUM_REQ, DATA_WIDTH and MAX_BURST.
REQ-034 The block SHALL contain one sub-module, rr_pick: a combinational rotating-priority picker with inputs req and ptr and outputs valid and idx.

Verification
REQ-035 The bench SHALL cover: NUM_REQ=4, MAX_BURST=4, req=0001 held for 6 cycles, FIFO empty -> gnt[0] in 6 consecutive cycles, fifo_wr high in cycles 2-7, owner=0 throughout.
REQ-036 The bench SHALL cover: req=1111 held -> gnt sequence 0,0,0,0,1,1,1,1,2,... with no gap cycle between owners.
REQ-037 The bench SHALL cover: fifo_almost_full=1 with fifo_wr=1 -> no gnt that cycle; then fifo_almost_full=1 with fifo_wr=0 -> exactly one gnt.
REQ-038 The bench SHALL cover: fifo_full=1 for 3 cycles mid-burst at burst_cnt=2 -> gnt=0 and owner held, then 2 more grants to the same owner after release.
REQ-039 The bench SHALL cover: arst pulsed during BURST with owner=2 -> fifo_wr=0 and busy=0 immediately, and after release with req=0100 the owner is 2 via a fresh IDLE arbitration.
REQ-040 The bench SHALL cover: NUM_REQ=3, MAX_BURST=1, req=101 -> gnt alternates 0,2,0,2 and rr_ptr wraps from 2 to 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, default sizes and index arithmetic for the FIFO write arbiter.
package fifo_arb_pkg;
   typedef enum logic {IDLE, BURST} arbState;
   localparam int DefNumReq = 4;
   localparam int DefDataWidth = 128;
   localparam int DefMaxBurst = 4;
   function automatic int wrapInc(input int v, input int n);
      return (v + 1) % n;
   endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bundle plus FIFO write port and arbiter status.
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(
   parameter int NUM_REQ = DefNumReq,
   parameter int DATA_WIDTH = DefDataWidth
);
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data;
   logic [NUM_REQ-1:0] gnt;
   logic fifo_wr;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic fifo_full;
   logic fifo_almost_full;
   logic [IW-1:0] owner;
   logic busy;
   modport master (output req, data, fifo_full, fifo_almost_full, input gnt, fifo_wr, fifo_data, owner, busy);
   modport slave (input req, data, fifo_full, fifo_almost_full, output gnt, fifo_wr, fifo_data, owner, busy);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: first set request at or after ptr, searching cyclically.
module rr_pick #(
   parameter int N = 4,
   parameter int IW = $clog2(N)
) (
   input logic [N-1:0] req,
   input logic [IW-1:0] ptr,
   output logic valid,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] cand;
   // Scan downwards so the closest index to ptr is written last and wins.
   always_comb begin
      valid = 1'b0;
      idx = '0;
      cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = IW'((int'(ptr) + k) % N);
         if (req[cand]) begin
            valid = 1'b1;
            idx = cand;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one registered FIFO write port.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
   parameter int NUM_REQ = DefNumReq,
   parameter int DATA_WIDTH = DefDataWidth,
   parameter int MAX_BURST = DefMaxBurst
) (
   input logic clk,
   input logic arst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MaxCnt = CW'(MAX_BURST);
   arbState st, nextSt;
   logic [IW-1:0] rr_ptr, owner, nextPtr, nextOwner, pickPtr, pickIdx, gntIdx;
   logic [CW-1:0] burst_cnt, nextCnt;
   logic [DATA_WIDTH-1:0] gntData;
   logic space, keep, pickValid, grant;
   // A write already in flight takes the last slot when almost full.
   assign space = !bus.fifo_full && !(bus.fifo_almost_full && bus.fifo_wr);
   assign keep = st == BURST && bus.req[owner] && burst_cnt < MaxCnt;
   assign pickPtr = st == BURST ? IW'(wrapInc(int'(owner), NUM_REQ)) : rr_ptr;
   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (.req(bus.req), .ptr(pickPtr), .valid(pickValid), .idx(pickIdx));
   always_comb begin
      nextSt = st;
      nextPtr = rr_ptr;
      nextOwner = owner;
      nextCnt = burst_cnt;
      grant = 1'b0;
      gntIdx = owner;
      if (space && keep) begin
         grant = 1'b1;
         nextCnt = burst_cnt + 1'b1;
      end else if (space) begin
         nextPtr = pickPtr;
         grant = pickValid;
         gntIdx = pickIdx;
         nextSt = pickValid ? BURST : IDLE;
         nextOwner = pickValid ? pickIdx : owner;
         nextCnt = pickValid ? CW'(1) : burst_cnt;
      end
   end
   assign gntData = bus.data[gntIdx];
   assign bus.gnt = (grant && !arst) ? (NUM_REQ'(1) << gntIdx) : '0;
   assign bus.busy = st == BURST;
   assign bus.owner = owner;
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         st <= IDLE;
         rr_ptr <= '0;
         owner <= '0;
         burst_cnt <= '0;
         bus.fifo_wr <= 1'b0;
         bus.fifo_data <= '0;
      end else begin
         st <= nextSt;
         rr_ptr <= nextPtr;
         owner <= nextOwner;
         burst_cnt <= nextCnt;
         bus.fifo_wr <= grant;
         if (grant) bus.fifo_data <= gntData;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios and random traffic against a grant-level reference model.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;
   localparam int N = 4;
   localparam int MB = 4;
   logic clk = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;
   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(128)) bus0 ();
   fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) bus1 ();
   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(128), .MAX_BURST(4)) u0 (.clk(clk), .arst(arst), .bus(bus0));
   fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) u1 (.clk(clk), .arst(arst), .bus(bus1));
   int total = 0;
   int bad = 0;
   int mPtr, mOwner, mCnt, lastIdx;
   bit mBusy, mWr;
   logic [127:0] mData;
   logic [127:0] words [4];
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic modelReset();
      mPtr = 0;
      mOwner = 0;
      mCnt = 0;
      mBusy = 1'b0;
      mWr = 1'b0;
      mData = '0;
      lastIdx = -1;
   endtask
   // Who should be granted this cycle: the burst owner while it has budget, else the next requester after it.
   function automatic int modelPick(input logic [3:0] r, input bit sp);
      int s;
      if (!sp) return -1;
      if (mBusy && r[mOwner] && mCnt < MB) return mOwner;
      s = mBusy ? (mOwner + 1) % N : mPtr;
      for (int k = 0; k < N; k++) if (r[(s + k) % N]) return (s + k) % N;
      return -1;
   endfunction
   task automatic setWords();
      for (int i = 0; i < N; i++) begin
         words[i] = {$urandom, $urandom, $urandom, $urandom};
         bus0.data[i] = words[i];
      end
   endtask
   task automatic tick();
      int e;
      logic [3:0] r;
      bit sp;
      logic [127:0] w;
      sp = !bus0.fifo_full && !(bus0.fifo_almost_full && mWr);
      r = bus0.req;
      e = modelPick(r, sp);
      w = e >= 0 ? words[e] : '0;
      check("gnt", 128'(bus0.gnt), e >= 0 ? 128'(1) << e : '0);
      check("fifo_wr", 128'(bus0.fifo_wr), 128'(mWr));
      check("fifo_data", bus0.fifo_data, mData);
      check("busy", 128'(bus0.busy), 128'(mBusy));
      if (mBusy) check("owner", 128'(bus0.owner), 128'(mOwner));
      @(posedge clk);
      #1;
      if (sp) begin
         if (mBusy && r[mOwner] && mCnt < MB) mCnt++;
         else begin
            if (mBusy) mPtr = (mOwner + 1) % N;
            mBusy = e >= 0;
            if (e >= 0) begin
               mOwner = e;
               mCnt = 1;
            end
         end
      end
      mWr = e >= 0;
      if (e >= 0) mData = w;
      lastIdx = e;
   endtask
   task automatic doReset();
      arst = 1'b1;
      bus0.req = '0;
      bus1.req = '0;
      bus0.fifo_full = 1'b0;
      bus0.fifo_almost_full = 1'b0;
      @(posedge clk);
      #1;
      arst = 1'b0;
      modelReset();
   endtask
   initial begin
      bus0.req = 4'hF;
      bus0.fifo_full = 1'b0;
      bus0.fifo_almost_full = 1'b0;
      bus1.req = 3'b111;
      bus1.data = {8'h33, 8'h22, 8'h11};
      bus1.fifo_full = 1'b0;
      bus1.fifo_almost_full = 1'b0;
      setWords();
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 128'(bus0.gnt), '0);
      check("rst_wr", 128'(bus0.fifo_wr), '0);
      check("rst_data", bus0.fifo_data, '0);
      check("rst_busy", 128'(bus0.busy), '0);
      check("rst_owner", 128'(bus0.owner), '0);
      check("rst_ptr", 128'(u0.rr_ptr), '0);
      doReset();
      // single requester keeps winning across its own burst limit
      bus0.req = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         setWords();
         #1;
         check("t35_gnt", 128'(bus0.gnt), 128'h1);
         if (i > 0) check("t35_owner", 128'(bus0.owner), '0);
         if (i > 0) check("t35_wr", 128'(bus0.fifo_wr), 128'h1);
         tick();
      end
      bus0.req = '0;
      #1;
      check("t35_wr_tail", 128'(bus0.fifo_wr), 128'h1);
      tick();
      #1;
      check("t35_wr_off", 128'(bus0.fifo_wr), '0);
      tick();
      doReset();
      bus0.req = 4'hF;
      for (int i = 0; i < 16; i++) begin
         setWords();
         #1;
         check("t36_seq", 128'(bus0.gnt), 128'(1) << ((i / 4) % 4));
         tick();
      end
      bus0.req = '0;
      #1;
      tick();
      #1;
      tick();
      doReset();
      bus0.req = 4'b0001;
      bus0.fifo_almost_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         setWords();
         #1;
         check("t37_afull", 128'(bus0.gnt), (i % 2 == 0) ? 128'h1 : '0);
         tick();
      end
      bus0.fifo_almost_full = 1'b0;
      bus0.req = '0;
      #1;
      tick();
      doReset();
      bus0.req = 4'b0011;
      for (int i = 0; i < 2; i++) begin
         setWords();
         #1;
         tick();
      end
      bus0.fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t38_stall_gnt", 128'(bus0.gnt), '0);
         check("t38_stall_owner", 128'(bus0.owner), '0);
         tick();
      end
      bus0.fifo_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         setWords();
         #1;
         check("t38_resume", 128'(bus0.gnt), i < 2 ? 128'h1 : 128'h2);
         tick();
      end
      bus0.req = '0;
      #1;
      tick();
      doReset();
      bus0.req = 4'b0100;
      for (int i = 0; i < 2; i++) begin
         setWords();
         #1;
         tick();
      end
      #1;
      check("t39_busy_pre", 128'(bus0.busy), 128'h1);
      check("t39_owner_pre", 128'(bus0.owner), 128'h2);
      arst = 1'b1;
      #1;
      check("t39_wr_now", 128'(bus0.fifo_wr), '0);
      check("t39_busy_now", 128'(bus0.busy), '0);
      check("t39_gnt_now", 128'(bus0.gnt), '0);
      @(posedge clk);
      #1;
      check("t39_lost", 128'(bus0.fifo_wr), '0);
      arst = 1'b0;
      modelReset();
      #1;
      check("t39_idle_gnt", 128'(bus0.gnt), 128'h4);
      check("t39_idle_busy", 128'(bus0.busy), '0);
      tick();
      #1;
      check("t39_owner", 128'(bus0.owner), 128'h2);
      tick();
      bus0.req = '0;
      #1;
      tick();
      #1;
      tick();
      doReset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (lastIdx == i) bus0.req[i] = 1'($urandom % 2);
            else if (!bus0.req[i]) bus0.req[i] = ($urandom % 3) == 0;
            else if ($urandom % 25 == 0) bus0.req[i] = 1'b0;
         end
         bus0.fifo_full = ($urandom % 6) == 0;
         bus0.fifo_almost_full = ($urandom % 4) == 0;
         setWords();
         #1;
         tick();
      end
      doReset();
      bus1.req = 3'b101;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("t40_gnt", 128'(bus1.gnt), (i % 2 == 1) ? 128'h4 : 128'h1);
         if (i > 0) check("t40_data", 128'(bus1.fifo_data), (i % 2 == 1) ? 128'h11 : 128'h33);
         @(posedge clk);
         #1;
         if (i > 0) check("t40_ptr", 128'(u1.rr_ptr), (i % 2 == 1) ? 128'h1 : '0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
